// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences PUSH/POP/ALU/SWAP commands onto an external
// stack through load/push/pop strobes and tracks its occupancy.
module stack_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [15:0]             cmd_data,
  output logic                    load,
  output logic                    push,
  output logic                    pop,
  output logic [15:0]             d,
  input  logic [15:0]             qtop,
  input  logic [15:0]             qnext,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             res,
  output logic [$clog2(DEPTH):0]  depth
);

  localparam int DW = $clog2(DEPTH) + 1;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP1,
    S_POP2,
    S_PUSH1,
    S_PUSH2,
    S_FIN
  } state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [15:0]     imm_q;
  logic [15:0]     a_q;
  logic [15:0]     b_q;
  logic            load_q;
  logic            push_q;
  logic            pop_q;
  logic [15:0]     d_q;
  logic            done_q;
  logic            err_q;
  logic [15:0]     res_q;
  logic [DW-1:0]   depth_q;
  logic [15:0]     alu_d;
  logic            bad_d;

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign load      = load_q;
  assign push      = push_q;
  assign pop       = pop_q;
  assign d         = d_q;
  assign done      = done_q;
  assign err       = err_q;
  assign res       = res_q;
  assign depth     = depth_q;

  // ALU result from the operands latched at acceptance
  always_comb begin
    alu_d = a_q + b_q;
    case (op_q)
      OP_SUB:  alu_d = a_q - b_q;
      OP_AND:  alu_d = a_q & b_q;
      OP_OR:   alu_d = a_q | b_q;
      OP_XOR:  alu_d = a_q ^ b_q;
      default: alu_d = a_q + b_q;
    endcase
  end

  // Under/overflow check on the offered command against current occupancy
  always_comb begin
    bad_d = 1'b0;
    if (cmd_op == OP_PUSH)
      bad_d = (depth_q == DW'(DEPTH));
    else if (cmd_op == OP_POP)
      bad_d = (depth_q == '0);
    else
      bad_d = (depth_q < DW'(2));
  end

  // Command sequencer with registered strobes and completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      load_q  <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      depth_q <= '0;
    end else begin
      load_q <= 1'b0;
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            imm_q <= cmd_data;
            a_q   <= qnext;
            b_q   <= qtop;
            if (bad_d) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              res_q   <= '0;
            end else if (cmd_op == OP_PUSH) begin
              state_q <= S_PUSH1;
              load_q  <= 1'b1;
              push_q  <= 1'b1;
              d_q     <= cmd_data;
            end else begin
              state_q <= S_POP1;
              pop_q   <= 1'b1;
            end
          end
        end
        S_POP1: begin
          if (op_q == OP_POP) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            res_q   <= b_q;
            depth_q <= depth_q - DW'(1);
          end else begin
            state_q <= S_POP2;
            pop_q   <= 1'b1;
          end
        end
        S_POP2: begin
          state_q <= S_PUSH1;
          load_q  <= 1'b1;
          push_q  <= 1'b1;
          d_q     <= (op_q == OP_SWAP) ? b_q : alu_d;
        end
        S_PUSH1: begin
          if (op_q == OP_SWAP) begin
            state_q <= S_PUSH2;
            load_q  <= 1'b1;
            push_q  <= 1'b1;
            d_q     <= a_q;
          end else if (op_q == OP_PUSH) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            res_q   <= imm_q;
            depth_q <= depth_q + DW'(1);
          end else begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            res_q   <= alu_d;
            depth_q <= depth_q - DW'(1);
          end
        end
        S_PUSH2: begin
          state_q <= S_FIN;
          done_q  <= 1'b1;
          res_q   <= a_q;
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed and random command checks of stack_ctrl
// against a queue-based stack model.
module tb_stack_ctrl;

  localparam int DEPTH = 8;
  localparam int DW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [15:0]   cmd_data = '0;
  logic          load, push, pop;
  logic [15:0]   d;
  logic [15:0]   qtop, qnext;
  logic          done, err;
  logic [15:0]   res;
  logic [DW-1:0] depth;

  int errors = 0;
  int checks = 0;

  logic [15:0] mq[$];

  logic [15:0] smem [DEPTH];
  int sp;

  always #50 clk = ~clk;

  stack_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .load(load), .push(push), .pop(pop), .d(d),
    .qtop(qtop), .qnext(qnext),
    .done(done), .err(err), .res(res), .depth(depth)
  );

  // Attached stack; its pointer is cleared with reset so that it
  // agrees with the controller's notion of an empty stack.
  always @(posedge clk) begin
    if (reset) sp <= 0;
    else if (load && push && !pop) begin
      if (sp < DEPTH) begin
        smem[sp] <= d;
        sp <= sp + 1;
      end
    end else if (pop && !load && !push) begin
      if (sp > 0) sp <= sp - 1;
    end
  end

  always_comb begin
    qtop  = (sp >= 1) ? smem[sp-1] : 16'h0;
    qnext = (sp >= 2) ? smem[sp-2] : 16'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f(input logic [2:0] op,
                                    input logic [15:0] a,
                                    input logic [15:0] b);
    case (op)
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return 16'h0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_strobes", {load, push, pop}, 0);
    chk("rst_d", d, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_res", res, 0);
    chk("rst_depth", depth, 0);
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] data);
    logic e_err;
    logic [15:0] e_res, a, b;
    int e_lat, e_pops;
    logic [15:0] exp_d[$];
    int lat, npop, npush;
    bit got;
    logic g_err;
    logic [15:0] g_res;
    int n;
    n = mq.size();
    e_err = 0; e_res = 0; e_pops = 0; e_lat = 1;
    if (op == 3'd0) begin
      if (n == DEPTH) e_err = 1;
      else begin
        e_res = data; exp_d.push_back(data);
        mq.push_back(data); e_lat = 2;
      end
    end else if (op == 3'd1) begin
      if (n == 0) e_err = 1;
      else begin
        e_res = mq.pop_back(); e_pops = 1; e_lat = 2;
      end
    end else if (n < 2) begin
      e_err = 1;
    end else begin
      b = mq.pop_back();
      a = mq.pop_back();
      e_pops = 2;
      if (op == 3'd7) begin
        mq.push_back(b); mq.push_back(a);
        exp_d.push_back(b); exp_d.push_back(a);
        e_res = a; e_lat = 5;
      end else begin
        e_res = f(op, a, b);
        mq.push_back(e_res); exp_d.push_back(e_res);
        e_lat = 4;
      end
    end

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    chk("ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; npop = 0; npush = 0; got = 0;
    g_err = 0; g_res = 0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      if (pop) npop++;
      if (push) begin
        npush++;
        chk("load_with_push", load, 1);
        if (npush <= exp_d.size())
          chk("push_d", d, exp_d[npush-1]);
      end
      if (done) begin
        got = 1; lat = k; g_err = err; g_res = res;
      end
    end
    chk("done_seen", got, 1);
    chk("latency", lat, e_lat);
    chk("err", g_err, e_err);
    chk("res", g_res, e_res);
    chk("pops", npop, e_pops);
    chk("pushes", npush, exp_d.size());
    chk("depth", depth, mq.size());
    if (mq.size() >= 1) chk("qtop", qtop, mq[mq.size()-1]);
    if (mq.size() >= 2) chk("qnext", qnext, mq[mq.size()-2]);
  endtask

  initial begin
    int dones;
    logic [2:0] rop;

    do_reset();
    do_cmd(3'd0, 16'h1234);
    do_cmd(3'd0, 16'h5678);
    do_cmd(3'd2, 16'h0000);
    chk("add_res_top", qtop, 16'h68AC);

    do_reset();
    do_cmd(3'd0, 16'd5);
    do_cmd(3'd0, 16'd3);
    do_cmd(3'd3, 16'h0);
    chk("sub_53", qtop, 16'h0002);
    do_reset();
    do_cmd(3'd0, 16'd3);
    do_cmd(3'd0, 16'd5);
    do_cmd(3'd3, 16'h0);
    chk("sub_35", qtop, 16'hFFFE);

    do_reset();
    do_cmd(3'd1, 16'h0);
    chk("uflow_depth0", depth, 0);
    do_cmd(3'd0, 16'h0042);
    do_cmd(3'd2, 16'h0);
    chk("uflow_depth1", depth, 1);

    do_reset();
    for (int i = 1; i <= DEPTH; i++) do_cmd(3'd0, 16'(i));
    do_cmd(3'd0, 16'hDEF0);
    chk("oflow_depth", depth, DEPTH);
    chk("oflow_top", qtop, DEPTH);

    do_reset();
    do_cmd(3'd0, 16'h1111);
    do_cmd(3'd0, 16'h2222);
    do_cmd(3'd7, 16'h0);
    chk("swap_top", qtop, 16'h1111);
    chk("swap_next", qnext, 16'h2222);

    do_reset();
    do_cmd(3'd0, 16'h0001);
    do_cmd(3'd0, 16'h0002);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_pop2", pop, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    cmd_valid = 1'b0;
    mq.delete();
    @(negedge clk);
    chk("mid_strobes", {load, push, pop}, 0);
    chk("mid_ready", cmd_ready, 1);
    chk("mid_depth", depth, 0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("mid_no_done", dones, 0);

    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    cmd_data = 16'h00AA;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    mq.push_back(16'h00AA);
    chk("held_once", dones, 1);
    chk("held_depth", depth, 1);
    chk("held_top", qtop, 16'h00AA);

    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rop = 3'd0;
      do_cmd(rop, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
